// File: rtl/led_pattern_counter.sv
// led_pattern_counter: prescaled LED pattern generator.
// A prescaler divides clk down to a step rate. On each step the LED register advances in the
// selected pattern: binary up, binary down, ring rotate or one-hot bounce.
// Optional feature: define LED_PATTERN_WRAP_EN to add the 'wrap' output, which pulses with
// 'step' on the step that completes a pattern period.
module led_pattern_counter #(
   parameter int unsigned C_WIDTH      = 16,
   parameter int unsigned C_MAX_COUNT  = 100000000,
   parameter int unsigned C_PRESCALE_W = 27
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic [1:0]         mode,
   output logic [C_WIDTH-1:0] led,
`ifdef LED_PATTERN_WRAP_EN
   output logic               wrap,
`endif
   output logic               step
);

   typedef enum logic [1:0] {ModeUp, ModeDown, ModeRing, ModeBounce} mode_e;
   typedef enum logic {DirLeft, DirRight} dir_e;

   localparam logic [C_PRESCALE_W-1:0] PrescLast = C_PRESCALE_W'(C_MAX_COUNT - 1);
   localparam logic [C_PRESCALE_W-1:0] PrescOne  = C_PRESCALE_W'(1);
   localparam logic [C_WIDTH-1:0]      LedOne    = C_WIDTH'(1);
   localparam logic [C_WIDTH-1:0]      LedTwo    = C_WIDTH'(2);
   localparam logic [C_WIDTH-1:0]      LedTop    = {1'b1, {(C_WIDTH-1){1'b0}}};

   logic [C_PRESCALE_W-1:0] presc_q;
   mode_e                   mode_q;
   dir_e                    dir_q;

   logic               mode_change;
   logic               step_event;
   logic               led_onehot;
   logic [C_WIDTH-1:0] led_init;
   logic [C_WIDTH-1:0] led_next;
   dir_e               dir_next;

   assign mode_change = (mode != mode_q);
   assign step_event  = en && (presc_q == PrescLast);
   assign led_onehot  = (led != '0) && ((led & (led - LedOne)) == '0);
   // Ring and bounce (mode[1] set) start from bit 0; the counters start from zero.
   assign led_init    = mode[1] ? LedOne : '0;

   // Next pattern value and bounce direction for a step in the current mode.
   always_comb begin
      led_next = led;
      dir_next = dir_q;
      case (mode_q)
         ModeUp:   led_next = led + LedOne;
         ModeDown: led_next = led - LedOne;
         ModeRing: begin
            if (led_onehot) begin
               led_next = {led[C_WIDTH-2:0], led[C_WIDTH-1]};
            end else begin
               led_next = LedOne;
            end
         end
         ModeBounce: begin
            if (!led_onehot) begin
               // Corrupted state: restart the sweep from bit 0.
               led_next = LedOne;
               dir_next = DirLeft;
            end else if (dir_q == DirLeft) begin
               if (led == LedTop) begin
                  led_next = led >> 1;
                  dir_next = DirRight;
               end else begin
                  led_next = led << 1;
               end
            end else begin
               if (led == LedOne) begin
                  led_next = led << 1;
                  dir_next = DirLeft;
               end else begin
                  led_next = led >> 1;
               end
            end
         end
         default: ;
      endcase
   end

   // Prescaler, mode register and LED state; a mode change overrides enable and step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
         mode_q  <= ModeUp;
         dir_q   <= DirLeft;
         led     <= '0;
         step    <= 1'b0;
      end else if (mode_change) begin
         mode_q  <= mode_e'(mode);
         presc_q <= '0;
         dir_q   <= DirLeft;
         led     <= led_init;
         step    <= 1'b0;
      end else if (en) begin
         if (step_event) begin
            presc_q <= '0;
            led     <= led_next;
            dir_q   <= dir_next;
            step    <= 1'b1;
         end else begin
            presc_q <= presc_q + PrescOne;
            step    <= 1'b0;
         end
      end else begin
         step <= 1'b0;
      end
   end

`ifdef LED_PATTERN_WRAP_EN
   logic wrap_event;

   // Detect the step that closes one full period of the current pattern.
   always_comb begin
      wrap_event = 1'b0;
      case (mode_q)
         ModeUp:     wrap_event = (led == '1);
         ModeDown:   wrap_event = (led == '0);
         ModeRing:   wrap_event = (led == LedTop);
         ModeBounce: wrap_event = (led == LedTwo) && (led_next == LedOne);
         default:    wrap_event = 1'b0;
      endcase
   end

   // Registered wrap pulse, aligned with step; never set by a mode-change load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrap <= 1'b0;
      end else if (mode_change) begin
         wrap <= 1'b0;
      end else begin
         wrap <= step_event && wrap_event;
      end
   end
`endif

endmodule

// File: doc/led_pattern_counter.md
Name: led_pattern_counter

Overview:
Parametrised successor to the board LED counter. A prescaler divides the 100 MHz clock down to a step rate. On each step, a C_WIDTH-bit LED register advances in one of four runtime-selectable patterns: binary up, binary down, ring rotate, or bounce. It sits under the board top level and drives led[] directly; the top level ties reset to btnC.

Parameters:
C_WIDTH, 16, LED register width; legal range 2..32.
C_MAX_COUNT, 100000000, clocks per step; legal minimum 1.
C_PRESCALE_W, 27, prescaler width; must satisfy 2^C_PRESCALE_W >= C_MAX_COUNT.

Ports:
clk  input  1  system clock, 100 MHz, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
en  input  1  count enable; 0 freezes the prescaler and led.
mode  input  2  pattern select: 0 up, 1 down, 2 ring, 3 bounce.
led  output  C_WIDTH  current pattern value, registered.
step  output  1  one-cycle pulse, high in the cycle led shows a new stepped value.

Behaviour:
- Reset (async assert, sync release to clk): presc=0, led=0, mode_q=0, dir=left, step=0.
- Prescaler, when en=1:
  - presc increments each clk.
  - At presc==C_MAX_COUNT-1: presc->0 and the step event fires at that same edge.
  - led updates at that edge; step is registered high for exactly the following cycle.
- Period: one step every C_MAX_COUNT enabled clocks. C_MAX_COUNT=1 gives a step every enabled clock.
- en=0: presc, led, dir and mode_q hold; step=0. Deasserting en mid-count resumes from the held presc value.
- Mode change: any cycle where mode != mode_q has top priority over en and the step event. That cycle:
  - mode_q<=mode and presc<=0.
  - step<=0.
  - led<=init(mode): up 0, down 0, ring 1, bounce 1 with dir=left.
  - Because mode_q resets to 0, a non-zero mode at reset release loads its init on the first clock.
- Step rules, with W=C_WIDTH and all arithmetic modulo 2^W:
  - up: led+1; all-ones wraps to 0.
  - down: led-1; 0 wraps to all-ones.
  - ring: rotate left one bit; bit W-1 moves to bit 0.
  - bounce: one-hot shift in direction dir.
    - led==2^(W-1) while moving left: shift right, dir<=right.
    - led==1 while moving right: shift left, dir<=left.
    - Period is 2W-2 steps; no end bit is repeated.
- Non-one-hot led in ring or bounce cannot occur by construction; if it does, the next step reloads 1 with dir=left.
- mode is treated as synchronous to clk; the caller synchronises switch inputs.

Optional Feature:
Macro LED_PATTERN_WRAP_EN.
- Defined: adds output port wrap (1 bit). wrap pulses together with step on a period-completing step:
  - up: all-ones->0.
  - down: 0->all-ones.
  - ring: bit W-1->bit 0.
  - bounce: bit 1->bit 0 while moving right.
  - Never pulses on a mode-change load.
  - Reset value 0.
- Undefined: no wrap port and no extra logic. All other behaviour is identical.

Test Plan:
1. Reset behaviour (W=4, MAX=4, mode=0): reset high 20 clks, then low -> led=0; step every 4th clk; led 0,1,2,...,15,0.
2. Down mode, MAX=1: mode=1 -> load led=0, then one step per clk giving 15,14,...,0,15. With LED_PATTERN_WRAP_EN, wrap is high only on the 0->15 step.
3. Bounce, W=4, MAX=2: mode=3 -> led 1,2,4,8,4,2,1,2 on successive steps (period 6). A wrap pulse appears on the 2->1 step only.
4. Enable hold (mode=2, MAX=4): drop en for 10 clks at presc=2 -> led and step frozen. After re-enable, the next step occurs 2 clks later; the ring advances 1->2.
5. Mode change mid-count: mode 0 at led=5, presc=2, switch to mode 2 -> next clk led=1, presc=0, step=0; the first ring step follows 4 clks later.
6. Async reset mid-operation: assert reset between clock edges during bounce -> led=0 and step=0 immediately, without waiting for a clk edge. After release with mode=3, led=1 on the first clk.
